// File: rtl/if_pkg.sv
// Shared IF-stage definitions: reset PC, NOP encoding, fetch FSM states and
// the {pc, inst} payload buffered between fetch and decode.
package if_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} pairs; clear beats push and pop.
// Head is read straight from the storage registers, so a push shows up one cycle later.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage body: fetches at pc over req/gnt/rvalid, buffers {pc, inst} pairs
// and hands them to decode over valid/ready; flush kills in-flight and buffered work.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = if_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] pc,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    fetch_state_t   state;
    logic [31:0]    inflight_pc;
    logic [CW-1:0]  count;
    logic           empty;
    logic           full;
    fetch_entry_t   head;
    fetch_entry_t   wentry;
    logic           outstanding;
    logic           pop;
    logic           push;
    logic           room;
    logic           grant;
    logic           issue_ok;
    logic [OW-1:0]  occupancy;

    assign outstanding = (state == WAIT) || (state == DROP);
    assign pop         = ~empty & id_ready;
    assign room        = ~full | pop;

    // The in-flight fetch holds a slot until pushed; the head leaving this cycle frees one.
    assign occupancy = OW'(count) + OW'(outstanding) - OW'(pop);
    assign issue_ok  = en & ~flush & room & (occupancy < OW'(BUF_DEPTH));

    assign imem_req  = (state == REQ) || ((state == WAIT) && imem_rvalid && issue_ok);
    assign imem_addr = pc;
    assign grant     = imem_req & imem_gnt;
    assign pc_stall  = ~grant;
    assign push      = (state == WAIT) && imem_rvalid && !flush;

    assign wentry.pc   = inflight_pc;
    assign wentry.inst = imem_rdata;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (wentry),
        .rdata (head),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign id_valid = ~empty;
    assign id_inst  = id_valid ? head.inst : NOP_INST;
    assign id_pc    = id_valid ? head.pc   : 32'h0;

    // Fetch FSM; flush overrides every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            inflight_pc <= RESET_PC;
        end else begin
            if (grant) inflight_pc <= pc;
            if (flush) begin
                case (state)
                    REQ:     state <= imem_gnt    ? DROP : IDLE;
                    WAIT:    state <= imem_rvalid ? IDLE : DROP;
                    DROP:    state <= imem_rvalid ? IDLE : DROP;
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: if (issue_ok) state <= REQ;
                    REQ:  if (imem_gnt) state <= WAIT;
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (!issue_ok)     state <= IDLE;
                            else if (imem_gnt) state <= WAIT;
                            else               state <= REQ;
                        end
                    end
                    DROP: if (imem_rvalid) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized self-checking bench for if_fetch_unit: the bench owns the PC register
// and a one-outstanding memory, and expects decode to see the contiguous pc stream since the last redirect.
module tb_if_fetch_unit;
    import if_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [31:0] pc;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    if_fetch_unit #(
        .BUF_DEPTH (2),
        .NOP_INST  (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .flush       (flush),
        .pc          (pc),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Memory contents: a pc-dependent word that can never equal NOP or 0xDEADBEEF for aligned pcs.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    int unsigned gnt_pct   = 100;
    int unsigned ready_pct = 100;
    int unsigned flush_pct = 0;
    int unsigned en_pct    = 100;
    int unsigned min_lat   = 0;
    int unsigned max_lat   = 0;

    logic [31:0] exp_pc;
    logic [31:0] mem_addr;
    logic [31:0] flush_tgt;
    bit          mem_busy;
    int          mem_wait;
    bit          stray;
    bit          poison;
    bit          flush_once;
    int          delivered;
    int          n_grant;
    bit          s_req;
    bit          s_stall;
    bit          s_valid;
    logic [31:0] s_addr;

    // One bench cycle: drive at the negedge, check at +1, step the PC and memory models.
    task automatic step();
        bit          rv_real;
        logic [31:0] tgt;
        logic [31:0] npc;
        rv_real = 1'b0;
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stray       = 1'b0;
        end else if (mem_busy && mem_wait == 0) begin
            imem_rvalid = 1'b1;
            rv_real     = 1'b1;
            imem_rdata  = poison ? 32'hDEAD_BEEF : inst_of(mem_addr);
            poison      = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
        id_ready = ($urandom_range(99) < ready_pct);
        en       = ($urandom_range(99) < en_pct);
        if (flush_once) begin
            flush      = 1'b1;
            tgt        = flush_tgt;
            flush_once = 1'b0;
        end else begin
            flush = ($urandom_range(99) < flush_pct);
            tgt   = $urandom & 32'hFFFF_FFFC;
        end
        #1;
        s_req   = imem_req;
        s_stall = pc_stall;
        s_valid = id_valid;
        s_addr  = imem_addr;
        chk("imem_addr", imem_addr, pc);
        if (mem_busy && !rv_real) chk("one_outstanding", imem_req, 1'b0);
        if (!id_valid) begin
            chk("empty_inst", id_inst, 32'h0000_0013);
            chk("empty_pc", id_pc, 32'h0);
        end else begin
            chk("no_stale_data", id_inst == 32'hDEAD_BEEF, 1'b0);
        end
        if (id_valid && id_ready && !flush) begin
            chk("id_pc", id_pc, exp_pc);
            chk("id_inst", id_inst, inst_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (imem_req && imem_gnt) n_grant++;
        if (rv_real) mem_busy = 1'b0;
        else if (mem_busy) mem_wait--;
        if (imem_req && imem_gnt) begin
            mem_busy = 1'b1;
            mem_addr = pc;
            mem_wait = int'($urandom_range(max_lat, min_lat));
        end
        if (flush) begin
            npc    = tgt;
            exp_pc = tgt;
        end else if (!pc_stall) begin
            npc = pc + 32'd4;
        end else begin
            npc = pc;
        end
        @(posedge clk);
        @(negedge clk);
        pc = npc;
    endtask

    // Called at a negedge; checks the asynchronous reset values before releasing.
    task automatic do_reset();
        rst_n       = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        id_ready    = 1'b0;
        pc          = RESET_PC;
        exp_pc      = RESET_PC;
        mem_busy    = 1'b0;
        mem_wait    = 0;
        poison      = 1'b0;
        stray       = 1'b0;
        flush_once  = 1'b0;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_stall", pc_stall, 1'b1);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_inst", id_inst, 32'h0000_0013);
        chk("rst_pc", id_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic knobs(input int unsigned g, input int unsigned r, input int unsigned e,
                         input int unsigned lo, input int unsigned hi);
        gnt_pct   = g;
        ready_pct = r;
        en_pct    = e;
        min_lat   = lo;
        max_lat   = hi;
        flush_pct = 0;
    endtask

    // A push into a full buffer that is not draining would be an overflow.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && dut.u_fifo.full && !dut.pop && !flush) chk("no_overflow", dut.push, 1'b0);
    end

    initial begin
        int d0;
        int g0;
        rst_n       = 1'b0;
        en          = 1'b0;
        flush       = 1'b0;
        pc          = RESET_PC;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        delivered   = 0;
        n_grant     = 0;
        @(negedge clk);

        // Zero-wait memory: first delivery three cycles after release, then one per cycle.
        knobs(100, 100, 100, 0, 0);
        do_reset();
        d0 = delivered;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_valid", s_valid, (i >= 3));
        end
        chk("t1_count", delivered - d0, 7);

        // Decode stalled: exactly two fetches fill the buffer, then fetch stops.
        knobs(100, 0, 100, 0, 0);
        do_reset();
        g0 = n_grant;
        repeat (8) step();
        chk("t2_grants", n_grant - g0, 2);
        chk("t2_req", s_req, 1'b0);
        chk("t2_stall", s_stall, 1'b1);
        chk("t2_valid", s_valid, 1'b1);
        ready_pct = 100;
        d0 = delivered;
        repeat (2) step();
        chk("t2_drain", delivered - d0, 2);

        // Grant withheld three cycles: request and address held, pc stalled.
        knobs(0, 100, 100, 0, 0);
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_req", s_req, 1'b1);
            chk("t3_stall", s_stall, 1'b1);
            chk("t3_addr", s_addr, RESET_PC);
        end
        g0 = n_grant;
        d0 = delivered;
        gnt_pct = 100;
        en_pct  = 0;
        step();
        chk("t3_grant_stall", s_stall, 1'b0);
        gnt_pct = 0;
        repeat (5) step();
        chk("t3_grants", n_grant - g0, 1);
        chk("t3_pushes", delivered - d0, 1);

        // Flush while waiting; the late 0xDEADBEEF response must be dropped.
        knobs(100, 100, 100, 2, 2);
        do_reset();
        step();
        step();
        flush_once = 1'b1;
        flush_tgt  = 32'h0000_1000;
        poison     = 1'b1;
        step();
        step();
        chk("t4_valid", s_valid, 1'b0);
        chk("t4_req", s_req, 1'b0);
        min_lat = 0;
        max_lat = 0;
        d0 = delivered;
        repeat (10) step();
        chk("t4_resume", delivered - d0 >= 4, 1'b1);

        // Flush coincident with rvalid while the buffer fills.
        knobs(100, 0, 100, 0, 0);
        do_reset();
        step();
        step();
        step();
        flush_once = 1'b1;
        flush_tgt  = 32'h0000_2000;
        step();
        chk("t5_flush_req", s_req, 1'b0);
        step();
        chk("t5_valid", s_valid, 1'b0);
        chk("t5_idle_req", s_req, 1'b0);
        step();
        chk("t5_reissue", s_req, 1'b1);
        chk("t5_addr", s_addr, 32'h0000_2000);

        // Reset in the middle of a fetch; a stray rvalid afterwards is ignored.
        knobs(100, 0, 100, 3, 3);
        do_reset();
        step();
        step();
        step();
        en_pct = 0;
        do_reset();
        stray = 1'b1;
        step();
        step();
        chk("t6_valid", s_valid, 1'b0);
        chk("t6_req", s_req, 1'b0);
        en_pct = 100;
        step();
        step();
        chk("t6_reissue", s_req, 1'b1);

        // Randomized traffic: grant, ready, enable, latency and flush all vary.
        do_reset();
        d0 = delivered;
        for (int p = 0; p < 20; p++) begin
            knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 60),
                  0, $urandom_range(3));
            flush_pct = $urandom_range(8);
            repeat (150) step();
        end
        knobs(100, 100, 0, 0, 0);
        repeat (20) step();
        chk("drain_valid", s_valid, 1'b0);
        chk("drain_mem_idle", mem_busy, 1'b0);
        chk("rand_progress", delivered - d0 > 200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
